// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly address sequencer for an in-place radix-2 DIT FFT with start/busy/done handshake.
// Optional build macro FFT_SEQ_SCALE_EN: assert scale on every write (divide by 2 per stage).
module fft_stage_sequencer #(
  parameter int N_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b,
  output logic [N_LOG2-1:0] stage,
  output logic              scale
);

  localparam int L = N_LOG2;
  localparam int unsigned S_LAST_I = N_LOG2 - 1;
  localparam logic [L-1:0] S_LAST = S_LAST_I[L-1:0];
  localparam logic [L-1:0] ONE    = {{(L-1){1'b0}}, 1'b1};
  localparam logic [L-2:0] J_LAST = {(L-1){1'b1}};
  localparam logic [L-2:0] J_ONE  = {{(L-2){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_GAP   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t       state_r, state_nx_s;
  logic [L-1:0] s_r, s_nx_s;
  logic [L-2:0] j_r, j_nx_s;

  logic         rd_en_s, busy_s, done_s;
  logic [L-1:0] addr_a_s, addr_b_s, j_ext_s, k_s, tw_full_s;
  logic [L-2:0] tw_s;

  // State and loop counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      s_r     <= {L{1'b0}};
      j_r     <= {(L-1){1'b0}};
    end else begin
      state_r <= state_nx_s;
      s_r     <= s_nx_s;
      j_r     <= j_nx_s;
    end
  end

  // Next-state and counter advance
  always_comb begin
    state_nx_s = state_r;
    s_nx_s     = s_r;
    j_nx_s     = j_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_RUN;
          s_nx_s     = {L{1'b0}};
          j_nx_s     = {(L-1){1'b0}};
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (j_r == J_LAST) begin
          j_nx_s     = {(L-1){1'b0}};
          state_nx_s = (s_r < S_LAST) ? ST_GAP : ST_FLUSH;
        end else begin
          j_nx_s = j_r + J_ONE;
        end
      end
      // Bubble keeps the next stage's first read clear of this stage's last write
      ST_GAP: begin
        state_nx_s = ST_RUN;
        s_nx_s     = s_r + ONE;
        j_nx_s     = {(L-1){1'b0}};
      end
      ST_FLUSH: state_nx_s = ST_DONE;
      ST_DONE: begin
        state_nx_s = ST_IDLE;
        s_nx_s     = {L{1'b0}};
      end
      default: begin
        state_nx_s = ST_IDLE;
        s_nx_s     = {L{1'b0}};
        j_nx_s     = {(L-1){1'b0}};
      end
    endcase
  end

  // Read-side values for the upcoming cycle, from the next-state counters
  always_comb begin
    rd_en_s   = (state_nx_s == ST_RUN);
    busy_s    = (state_nx_s != ST_IDLE);
    done_s    = (state_nx_s == ST_DONE);
    j_ext_s   = {1'b0, j_nx_s};
    k_s       = j_ext_s & ~({L{1'b1}} << s_nx_s);
    tw_full_s = k_s << (S_LAST - s_nx_s);
    if (rd_en_s) begin
      addr_a_s = ((j_ext_s >> s_nx_s) << (s_nx_s + ONE)) | k_s;
      addr_b_s = addr_a_s | (ONE << s_nx_s);
      tw_s     = tw_full_s[L-2:0];
    end else begin
      addr_a_s = {L{1'b0}};
      addr_b_s = {L{1'b0}};
      tw_s     = {(L-1){1'b0}};
    end
  end

  // Registered outputs; the write side is the read side delayed by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= {L{1'b0}};
      rd_addr_b <= {L{1'b0}};
      tw_addr   <= {(L-1){1'b0}};
      stage     <= {L{1'b0}};
      wr_en     <= 1'b0;
      wr_addr_a <= {L{1'b0}};
      wr_addr_b <= {L{1'b0}};
      scale     <= 1'b0;
    end else begin
      busy      <= busy_s;
      done      <= done_s;
      rd_en     <= rd_en_s;
      rd_addr_a <= addr_a_s;
      rd_addr_b <= addr_b_s;
      tw_addr   <= tw_s;
      stage     <= s_nx_s;
      wr_en     <= rd_en;
      wr_addr_a <= rd_addr_a;
      wr_addr_b <= rd_addr_b;
`ifdef FFT_SEQ_SCALE_EN
      scale     <= rd_en;
`else
      scale     <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed self-checking bench for fft_stage_sequencer at N_LOG2 = 3 (N = 8).
module tb_fft_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, rd_en, wr_en, scale;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, stage;
  logic [1:0] tw_addr;

  int total = 0;
  int bad   = 0;

  fft_stage_sequencer #(.N_LOG2(3)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .stage(stage), .scale(scale)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {10'd0, busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
            wr_en, wr_addr_a, wr_addr_b, stage, scale};
  endfunction

  initial begin
    int ea [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int eb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int et [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int idx, rdc, wrc, dcnt, n, exp_stage;
    logic exp_rd, prev_en;
    logic [2:0] prev_a, prev_b;

    // Reset held 3 cycles with start asserted
    start = 1'b1;
    repeat (3) tick();
    chk("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk("start_in_reset_ignored", all_outs(), 32'd0);

    // One full transform, cycle by cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0; rdc = 0; wrc = 0; prev_en = 1'b0; prev_a = 3'd0; prev_b = 3'd0;
    for (int c = 1; c <= 17; c++) begin
      exp_rd = (c >= 1 && c <= 4) || (c >= 6 && c <= 9) || (c >= 11 && c <= 14);
      exp_stage = (c <= 5) ? 0 : (c <= 10) ? 1 : (c <= 16) ? 2 : 0;
      chk("rd_en", {31'd0, rd_en}, {31'd0, exp_rd});
      if (exp_rd) begin
        chk("rd_addr_a", {29'd0, rd_addr_a}, ea[idx]);
        chk("rd_addr_b", {29'd0, rd_addr_b}, eb[idx]);
        chk("tw_addr", {30'd0, tw_addr}, et[idx]);
      end
      chk("wr_en", {31'd0, wr_en}, {31'd0, prev_en});
      if (prev_en) begin
        chk("wr_addr_a", {29'd0, wr_addr_a}, {29'd0, prev_a});
        chk("wr_addr_b", {29'd0, wr_addr_b}, {29'd0, prev_b});
      end
      chk("busy", {31'd0, busy}, (c <= 16) ? 32'd1 : 32'd0);
      chk("done", {31'd0, done}, (c == 16) ? 32'd1 : 32'd0);
      chk("stage", {29'd0, stage}, exp_stage);
`ifdef FFT_SEQ_SCALE_EN
      chk("scale", {31'd0, scale}, {31'd0, prev_en});
`else
      chk("scale", {31'd0, scale}, 32'd0);
`endif
      if (rd_en && wr_en)
        chk("no_rw_collision",
            {31'd0, (rd_addr_a != wr_addr_a) && (rd_addr_a != wr_addr_b) &&
                    (rd_addr_b != wr_addr_a) && (rd_addr_b != wr_addr_b)}, 32'd1);
      if (rd_en) rdc++;
      if (wr_en) wrc++;
      prev_en = exp_rd;
      if (exp_rd) begin
        prev_a = ea[idx][2:0];
        prev_b = eb[idx][2:0];
        idx++;
      end
      tick();
    end
    chk("rd_count", rdc, 12);
    chk("wr_count", wrc, 12);

    // Start held high: back-to-back transforms, done in cycles 16 and 33
    start = 1'b1;
    dcnt = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done) dcnt++;
      chk("cont_done", {31'd0, done}, (c == 16 || c == 33) ? 32'd1 : 32'd0);
      chk("cont_busy", {31'd0, busy}, (c == 17 || c == 34) ? 32'd0 : 32'd1);
    end
    chk("cont_done_count", dcnt, 2);
    start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_mid_traffic", all_outs(), 32'd0);

    // Reset in cycle 7 of a transform
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_outs", all_outs(), 32'd0);
    rdc = 0; wrc = 0; dcnt = 0;
    repeat (20) begin
      tick();
      if (rd_en) rdc++;
      if (wr_en) wrc++;
      if (done) dcnt++;
    end
    chk("abort_no_wr", wrc, 0);
    chk("abort_no_rd", rdc, 0);
    chk("abort_no_done", dcnt, 0);

    // A fresh start after the abort completes in 16 cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("restart_latency", n, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Control sequencer for an in-place radix-2 decimation-in-time FFT built around the single shared combinational `butterfly` (32-bit packed complex operands `{re[31:16], im[15:0]}`, twiddle `W`). It walks all stages and butterflies of an N-point transform. Each cycle it issues sample-RAM read addresses and a twiddle-ROM address, then issues the matching write-back one cycle later. It also owns the start/busy/done handshake toward the system controller. Sample RAM holds input in bit-reversed order; sample RAM and twiddle ROM are synchronous-read with 1-cycle latency.

## Interface
- `N_LOG2`, default 3: log2 of transform size N; legal range 2..10.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `start` in 1: request a transform; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted through the DONE cycle inclusive.
- `done` out 1: single-cycle pulse; the final write has already been issued.
- `rd_en` out 1: sample-RAM read strobe for both ports.
- `rd_addr_a` out N_LOG2: top butterfly input address (A).
- `rd_addr_b` out N_LOG2: bottom butterfly input address (B).
- `tw_addr` out N_LOG2-1: twiddle-ROM index k·N/2^(s+1); driven in the same cycle as `rd_addr_*`.
- `wr_en` out 1: sample-RAM write strobe; `out0` is written to `wr_addr_a` and `out1` to `wr_addr_b`.
- `wr_addr_a` out N_LOG2: `rd_addr_a` delayed one cycle.
- `wr_addr_b` out N_LOG2: `rd_addr_b` delayed one cycle.
- `stage` out N_LOG2 bits: current stage index s, 0..N_LOG2-1.
- `scale` out 1: datapath must arithmetic-shift `out0`/`out1` right by 1 this write (see Configuration).

## Operation
- Counters: stage s in 0..L-1, where L = N_LOG2; butterfly index j in 0..N/2-1. half = 2^s. k = j & (half-1). g = j >> s.
- Address generation: `rd_addr_a` = g·2·half + k; `rd_addr_b` = `rd_addr_a` + half; `tw_addr` = k << (L-1-s). All are registered outputs valid while `rd_en` = 1.
- States:
  - IDLE: `start` → RUN with s = 0, j = 0.
  - RUN: `rd_en` = 1 and j++ every cycle. At j = N/2-1: go to GAP if s < L-1, otherwise go to FLUSH.
  - GAP: `rd_en` = 0, one cycle. The last write of stage s lands here. Then s++, j = 0, → RUN. The bubble is mandatory: it prevents a stage s+1 read from colliding with a stage s write.
  - FLUSH: `rd_en` = 0; the final write lands. → DONE.
  - DONE: `done` = 1 for one cycle → IDLE.
- Write side: `wr_en`, `wr_addr_a`/`wr_addr_b` and `scale` are a one-cycle delayed copy of the read side. `wr_en` in cycle t+1 equals `rd_en` in cycle t.
- `start` while not IDLE, including the DONE cycle, is ignored and not queued.
- Reset values: state IDLE, s = 0, j = 0. All outputs are 0.
- `rst` mid-transform: the next cycle is IDLE with all outputs 0. The write-side pipeline is cleared, so no trailing `wr_en` is issued. RAM contents are undefined and no `done` is issued.

## Timing
- `start` sampled high in IDLE at edge 0 → first `rd_en` in cycle 1 → first `wr_en` in cycle 2.
- Throughput: one butterfly per cycle within a stage.
- Latency from start cycle to `done` cycle = L·N/2 + L + 1. N = 8 gives 16; N = 1024 gives 5131.
- Write counts: exactly L·N/2 `wr_en` cycles and exactly L·N/2 `rd_en` cycles per transform.
- Next `start` is accepted in the cycle after `done`, i.e. the first IDLE cycle.

## Configuration
- `FFT_SEQ_SCALE_EN` defined: `scale` is asserted on every write of every stage (block-floating /2 per stage, total 1/N). This prevents overflow of the 16-bit real/imaginary fields.
- `FFT_SEQ_SCALE_EN` undefined: `scale` is tied to 0 and the datapath performs unscaled writes. The port is present in both builds.

## Test plan
- Reset: hold `rst` 3 cycles, mid-traffic → all outputs 0. `start` during `rst` is ignored.
- N_LOG2 = 3, pulse `start`:
  - stage 0 reads (a,b) = (0,1),(2,3),(4,5),(6,7), `tw_addr` 0,0,0,0;
  - stage 1 reads (0,2),(1,3),(4,6),(5,7), `tw_addr` 0,2,0,2;
  - stage 2 reads (0,4),(1,5),(2,6),(3,7), `tw_addr` 0,1,2,3;
  - `rd_en` low in cycles 5 and 10; `done` in cycle 16; 12 `wr_en` cycles, each one cycle after its read.
- Write alignment: every `wr_addr_*` equals the previous cycle's `rd_addr_*`. No read and write of the same address occur in one cycle across a stage boundary.
- `start` held high continuously for 40 cycles → transforms complete with `done` in cycles 16 and 33. No start is accepted while busy.
- `rst` asserted in cycle 7 of a transform → IDLE next cycle, no `wr_en` and no `done` afterwards. A new `start` then completes normally in 16 cycles.
- With `FFT_SEQ_SCALE_EN`: `scale` = 1 on all 12 writes; with A = B = {100, 0} and W = {1, 0}, the datapath writes {100, 0} and {0, 0}. Without the macro: `scale` = 0 throughout.
